// File: rtl/siso_if.sv
// siso_if: serial data bundle for siso; the tap view exists only when SISO_TAP_EN is defined
interface siso_if #(
    parameter int DEPTH = 4
);
    logic si;
    logic so;
`ifdef SISO_TAP_EN
    logic [DEPTH-1:0] tap;
    modport master (output si, input so, input tap);
    modport slave (input si, output so, output tap);
`else
    modport master (output si, input so);
    modport slave (input si, output so);
`endif
endinterface

// File: rtl/siso.sv
// siso: DEPTH-stage serial-in serial-out delay line; define SISO_TAP_EN to expose the parallel tap
module siso #(
    parameter int DEPTH = 4
) (
    input logic   clk,
    input logic   rst,
    siso_if.slave bus
);
    logic [DEPTH-1:0] r;
    // shift every edge: stage 0 takes si, each later stage takes its predecessor; rst clears all stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else begin
            r[0] <= bus.si;
            for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
        end
    end
    assign bus.so = r[DEPTH-1];
`ifdef SISO_TAP_EN
    assign bus.tap = r;
`endif
endmodule

// File: tb/tb_siso.sv
// tb_siso: checks siso at DEPTH 4, 1 and 8 against directed tables and a history-based model
module tb_siso;
    logic clk, rst, si;
    int total = 0, bad = 0;
    bit hs[$];
    bit hr[$];

    siso_if #(.DEPTH(4)) b4 ();
    siso_if #(.DEPTH(1)) b1 ();
    siso_if #(.DEPTH(8)) b8 ();
    assign b4.si = si;
    assign b1.si = si;
    assign b8.si = si;

    siso #(.DEPTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    siso #(.DEPTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    siso #(.DEPTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       si;
        logic       rst;
        logic       so4;
        logic       so1;
        logic       so8;
        logic [3:0] tap4;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    // bit that entered j edges before the latest one, or 0 if a reset edge happened since then
    function automatic logic model_bit(input int j);
        int n = hs.size() - 1;
        if (n - j < 0) return 1'b0;
        for (int k = n - j; k <= n; k++) if (hr[k]) return 1'b0;
        return hs[n-j];
    endfunction

    function automatic logic [63:0] model_tap(input int d);
        logic [63:0] v = '0;
        for (int j = 0; j < d; j++) v[j] = model_bit(j);
        return v;
    endfunction

    task automatic step(input logic s, input logic r);
        si = s;
        rst = r;
        @(posedge clk);
        hs.push_back(s);
        hr.push_back(r);
        @(negedge clk);
        chk("model_so4", {63'd0, b4.so}, {63'd0, model_bit(3)});
        chk("model_so1", {63'd0, b1.so}, {63'd0, model_bit(0)});
        chk("model_so8", {63'd0, b8.so}, {63'd0, model_bit(7)});
`ifdef SISO_TAP_EN
        chk("model_tap4", {60'd0, b4.tap}, model_tap(4));
        chk("model_tap1", {63'd0, b1.tap}, model_tap(1));
        chk("model_tap8", {56'd0, b8.tap}, model_tap(8));
`endif
    endtask

    initial begin
        si = 1'b0;
        rst = 1'b1;
        tbl[0]  = '{1, 1, 0, 0, 0, 4'b0000};
        tbl[1]  = '{1, 1, 0, 0, 0, 4'b0000};
        tbl[2]  = '{1, 0, 0, 1, 0, 4'b0001};
        tbl[3]  = '{0, 0, 0, 0, 0, 4'b0010};
        tbl[4]  = '{1, 0, 0, 1, 0, 4'b0101};
        tbl[5]  = '{0, 0, 1, 0, 0, 4'b1010};
        tbl[6]  = '{0, 0, 0, 0, 0, 4'b0100};
        tbl[7]  = '{0, 0, 1, 0, 0, 4'b1000};
        tbl[8]  = '{0, 0, 0, 0, 0, 4'b0000};
        tbl[9]  = '{0, 0, 0, 0, 1, 4'b0000};
        tbl[10] = '{0, 0, 0, 0, 0, 4'b0000};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].si, tbl[i].rst);
            chk($sformatf("tbl%0d_so4", i), {63'd0, b4.so}, {63'd0, tbl[i].so4});
            chk($sformatf("tbl%0d_so1", i), {63'd0, b1.so}, {63'd0, tbl[i].so1});
            chk($sformatf("tbl%0d_so8", i), {63'd0, b8.so}, {63'd0, tbl[i].so8});
`ifdef SISO_TAP_EN
            chk($sformatf("tbl%0d_tap4", i), {60'd0, b4.tap}, {60'd0, tbl[i].tap4});
`endif
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0);
            chk($sformatf("ones%0d_so4", i), {63'd0, b4.so}, {63'd0, i >= 4});
        end
        step(1'b1, 1'b1);
        chk("midrst_so4", {63'd0, b4.so}, 64'd0);
        chk("midrst_so8", {63'd0, b8.so}, 64'd0);
`ifdef SISO_TAP_EN
        chk("midrst_tap4", {60'd0, b4.tap}, 64'd0);
`endif
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0);
            chk($sformatf("postrst%0d_so4", i), {63'd0, b4.so}, 64'd0);
        end
        step(1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step(i == 1, 1'b0);
            chk($sformatf("pulse%0d_so8", i), {63'd0, b8.so}, {63'd0, i == 8});
        end
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/siso.md
# siso

Serial-in serial-out shift register: a single-bit serial stream enters on `si` and leaves on `so` delayed by `DEPTH` clock edges. It is a generic delay/alignment element for serial data paths, such as bit-stream retiming or pipeline balancing between serial stages. It is fully synchronous to one clock and has no handshake.

## Interface
- `DEPTH`, default 4: number of register stages. Legal range is 1 to 64.
- `clk`  input  1  rising-edge clock; all state changes occur here.
- `rst`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `si`  input  1  serial data in; sampled on every rising edge when `rst`=0.
- `so`  output  1  serial data out; driven directly from the last stage `r[DEPTH-1]`, with no combinational path from `si`.
- `tap`  output  `DEPTH`  parallel view of `r[DEPTH-1:0]`. Present only when `SISO_TAP_EN` is defined.

## Operation
- Internal state is the vector `r[DEPTH-1:0]`. Stage 0 is the input end; stage `DEPTH-1` drives `so`.
- On each rising edge with `rst`=1:
  - `r` <= all zeros.
  - `si` is ignored.
- On each rising edge with `rst`=0:
  - `r[0]` <= `si`.
  - `r[i]` <= `r[i-1]` for `i` = 1 to `DEPTH-1`.
  - The bit previously in `r[DEPTH-1]` is discarded.
- `so` = `r[DEPTH-1]` at all times.
- Reset values: `so`=0; `tap`=0 when present.
- The shift is unconditional. There is no enable and no hold state.
- `DEPTH`=1: the block degenerates to a single D flip-flop with synchronous clear (`so` = `si` delayed by one edge).

## Timing
- Latency: a bit sampled on `si` at rising edge k appears on `so` just after edge k+DEPTH-1. It stays valid until edge k+DEPTH.
- Reset mid-stream: the edge that samples `rst`=1 clears every stage, and `so` reads 0 after that edge. In-flight data is lost.
- Reset release: the first edge that samples `rst`=0 shifts normally and captures `si`.
- Outputs are glitch-free registered values. They update only on rising edges of `clk`.
- The block has no asynchronous behaviour. Until the first reset edge, the register contents are unspecified (X in simulation).

## Configuration
- `SISO_TAP_EN` defined:
  - adds the output port `tap[DEPTH-1:0]` = `r[DEPTH-1:0]`, registered, with reset value 0;
  - `tap[DEPTH-1]` always equals `so`.
- `SISO_TAP_EN` undefined: the port does not exist, and the behaviour of `so` is identical to the defined case.

## Test plan
Clock period is 20 time units. Unless stated otherwise, `DEPTH`=4 and `rst`=1 is held for 2 edges.
- Reset: hold `rst`=1 for 2 edges with `si`=1 -> `so`=0 (and `tap`=0000) after each edge.
- Pattern propagation: after reset, drive `si` = 1,0,1,0 on edges 1–4, then 0 for 5 more edges -> `so` after edges 1–9 = 0,0,0,1,0,1,0,0,0. With the tap, `tap` after edge 4 = 1010.
- Constant ones: `si`=1 for 8 edges -> `so` first reads 1 after edge 4 and stays 1 through edge 8.
- Reset mid-stream: load 1111, then assert `rst` for 1 edge with `si`=1 -> `so`=0 and `tap`=0000. The next 3 edges with `si`=0 keep `so`=0.
- `DEPTH`=1: drive `si` = 1,0,1 -> `so` follows `si` with a one-edge delay (1,0,1 after edges 1–3).
- `DEPTH`=8: a single 1 pulse on edge 1 -> `so`=1 only after edge 8, and 0 after edge 9.
